// File: rtl/vec_ram_arbiter_if.sv
// Bundle of the download, CPU and AVG ports of the vector RAM arbiter.
// Handshake: *_req and dl_wr are single-cycle pulses with no back-pressure; cpu_ack and
// avg_valid are one-cycle completion pulses, and their data is held until the next completion.
interface vec_ram_arbiter_if #(
  parameter int ADDR_W = 13,
  parameter int DATA_W = 8
);
  logic              dl_wr;
  logic [ADDR_W-1:0] dl_addr;
  logic [DATA_W-1:0] dl_data;
  logic              cpu_req;
  logic              cpu_we;
  logic [ADDR_W-1:0] cpu_addr;
  logic [DATA_W-1:0] cpu_din;
  logic [DATA_W-1:0] cpu_dout;
  logic              cpu_ack;
  logic              avg_req;
  logic [ADDR_W-2:0] avg_addr;
  logic [15:0]       avg_inst;
  logic              avg_valid;
  logic              ovf;

  modport master (
    output dl_wr, dl_addr, dl_data, cpu_req, cpu_we, cpu_addr, cpu_din, avg_req, avg_addr,
    input  cpu_dout, cpu_ack, avg_inst, avg_valid, ovf
  );

  modport slave (
    input  dl_wr, dl_addr, dl_data, cpu_req, cpu_we, cpu_addr, cpu_din, avg_req, avg_addr,
    output cpu_dout, cpu_ack, avg_inst, avg_valid, ovf
  );
endinterface

// File: rtl/vec_ram_arbiter.sv
// Single-port vector RAM shared by a ROM download port (highest priority), the CPU and
// the AVG instruction fetcher; CPU and AVG are arbitrated round-robin when they collide.
module vec_ram_arbiter #(
  parameter int ADDR_W = 13,
  parameter int DATA_W = 8
) (
  input  logic                clk,
  input  logic                rst,
  vec_ram_arbiter_if.slave    bus,
  output logic [1:0]          dbg_state_o
);

  typedef enum logic [1:0] {IDLE = 2'd0, CPU_WAIT = 2'd1, AVG_LO = 2'd2, AVG_FIN = 2'd3} state_e;

  state_e            state_q, state_d;
  logic              cpu_v_q, cpu_v_d;
  logic              cpu_we_q, cpu_we_d;
  logic [ADDR_W-1:0] cpu_a_q, cpu_a_d;
  logic [DATA_W-1:0] cpu_din_q, cpu_din_d;
  logic              cpu_rd_q, cpu_rd_d;
  logic              avg_v_q, avg_v_d;
  logic [ADDR_W-2:0] avg_a_q, avg_a_d;
  logic              last_cpu_q, last_cpu_d;
  logic [DATA_W-1:0] hi_q, hi_d;
  logic [DATA_W-1:0] cpu_dout_q, cpu_dout_d;
  logic              cpu_ack_q, cpu_ack_d;
  logic [15:0]       avg_inst_q, avg_inst_d;
  logic              avg_valid_q, avg_valid_d;
  logic              ovf_q, ovf_d;

  logic              fsm_re, fsm_we;
  logic [ADDR_W-1:0] fsm_addr;
  logic [DATA_W-1:0] fsm_wdata;

  logic [DATA_W-1:0] mem [2**ADDR_W];
  logic [DATA_W-1:0] ram_q;
  logic              ram_we, ram_re;
  logic [ADDR_W-1:0] ram_addr;
  logic [DATA_W-1:0] ram_wdata;

  // A fresh request can be granted in the cycle it arrives, so the slot is bypassed.
  logic              cpu_pend, avg_pend;
  logic              c_we;
  logic [ADDR_W-1:0] c_addr;
  logic [DATA_W-1:0] c_din;
  logic [ADDR_W-2:0] a_w;

  assign cpu_pend = cpu_v_q | bus.cpu_req;
  assign avg_pend = avg_v_q | bus.avg_req;
  assign c_we     = cpu_v_q ? cpu_we_q  : bus.cpu_we;
  assign c_addr   = cpu_v_q ? cpu_a_q   : bus.cpu_addr;
  assign c_din    = cpu_v_q ? cpu_din_q : bus.cpu_din;
  assign a_w      = avg_v_q ? avg_a_q   : bus.avg_addr;

  always_comb begin
    state_d     = state_q;
    cpu_v_d     = cpu_v_q;
    cpu_we_d    = cpu_we_q;
    cpu_a_d     = cpu_a_q;
    cpu_din_d   = cpu_din_q;
    cpu_rd_d    = cpu_rd_q;
    avg_v_d     = avg_v_q;
    avg_a_d     = avg_a_q;
    last_cpu_d  = last_cpu_q;
    hi_d        = hi_q;
    cpu_dout_d  = cpu_dout_q;
    cpu_ack_d   = 1'b0;
    avg_inst_d  = avg_inst_q;
    avg_valid_d = 1'b0;
    ovf_d       = ovf_q;
    fsm_re      = 1'b0;
    fsm_we      = 1'b0;
    fsm_addr    = '0;
    fsm_wdata   = '0;

    if (bus.cpu_req) begin
      if (cpu_v_q) begin
        ovf_d = 1'b1;
      end else begin
        cpu_v_d   = 1'b1;
        cpu_we_d  = bus.cpu_we;
        cpu_a_d   = bus.cpu_addr;
        cpu_din_d = bus.cpu_din;
      end
    end
    if (bus.avg_req) begin
      if (avg_v_q) begin
        ovf_d = 1'b1;
      end else begin
        avg_v_d = 1'b1;
        avg_a_d = bus.avg_addr;
      end
    end

    unique case (state_q)
      IDLE: begin
        if (!bus.dl_wr) begin
          // last_cpu only moves on contended grants, so ties alternate.
          if (cpu_pend && (!avg_pend || !last_cpu_q)) begin
            fsm_we    = c_we;
            fsm_re    = !c_we;
            fsm_addr  = c_addr;
            fsm_wdata = c_din;
            cpu_v_d   = 1'b0;
            cpu_rd_d  = !c_we;
            if (avg_pend) last_cpu_d = 1'b1;
            state_d   = CPU_WAIT;
          end else if (avg_pend) begin
            fsm_re   = 1'b1;
            fsm_addr = {a_w, 1'b0};
            avg_v_d  = 1'b1;
            avg_a_d  = a_w;
            if (cpu_pend) last_cpu_d = 1'b0;
            state_d  = AVG_LO;
          end
        end
      end
      CPU_WAIT: begin
        if (cpu_rd_q) cpu_dout_d = ram_q;
        cpu_ack_d = 1'b1;
        state_d   = IDLE;
      end
      AVG_LO: begin
        if (!bus.dl_wr) begin
          hi_d     = ram_q;
          fsm_re   = 1'b1;
          fsm_addr = {avg_a_q, 1'b1};
          state_d  = AVG_FIN;
        end
      end
      AVG_FIN: begin
        avg_inst_d  = {hi_q, ram_q};
        avg_valid_d = 1'b1;
        avg_v_d     = 1'b0;
        state_d     = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      cpu_v_q     <= 1'b0;
      cpu_we_q    <= 1'b0;
      cpu_a_q     <= '0;
      cpu_din_q   <= '0;
      cpu_rd_q    <= 1'b0;
      avg_v_q     <= 1'b0;
      avg_a_q     <= '0;
      last_cpu_q  <= 1'b0;
      hi_q        <= '0;
      cpu_dout_q  <= '0;
      cpu_ack_q   <= 1'b0;
      avg_inst_q  <= '0;
      avg_valid_q <= 1'b0;
      ovf_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      cpu_v_q     <= cpu_v_d;
      cpu_we_q    <= cpu_we_d;
      cpu_a_q     <= cpu_a_d;
      cpu_din_q   <= cpu_din_d;
      cpu_rd_q    <= cpu_rd_d;
      avg_v_q     <= avg_v_d;
      avg_a_q     <= avg_a_d;
      last_cpu_q  <= last_cpu_d;
      hi_q        <= hi_d;
      cpu_dout_q  <= cpu_dout_d;
      cpu_ack_q   <= cpu_ack_d;
      avg_inst_q  <= avg_inst_d;
      avg_valid_q <= avg_valid_d;
      ovf_q       <= ovf_d;
    end
  end

  // RAM port: download always wins; read data only changes on a cycle that reads.
  assign ram_we    = bus.dl_wr | fsm_we;
  assign ram_re    = !bus.dl_wr & fsm_re;
  assign ram_addr  = bus.dl_wr ? bus.dl_addr : fsm_addr;
  assign ram_wdata = bus.dl_wr ? bus.dl_data : fsm_wdata;

  always_ff @(posedge clk) begin
    if (ram_we) mem[ram_addr] <= ram_wdata;
    else if (ram_re) ram_q <= mem[ram_addr];
  end

  assign bus.cpu_dout  = cpu_dout_q;
  assign bus.cpu_ack   = cpu_ack_q;
  assign bus.avg_inst  = avg_inst_q;
  assign bus.avg_valid = avg_valid_q;
  assign bus.ovf       = ovf_q;
  assign dbg_state_o   = state_q;

endmodule

// File: tb/tb_vec_ram_arbiter.sv
// Directed bench for vec_ram_arbiter: download, CPU/AVG timing, arbitration, stalls, reset.
module tb_vec_ram_arbiter;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [1:0] dbg_state;
  int         checks = 0;
  int         errors = 0;
  int         cnt;

  localparam logic [1:0] S_IDLE = 2'd0, S_CPU_WAIT = 2'd1, S_AVG_LO = 2'd2, S_AVG_FIN = 2'd3;

  vec_ram_arbiter_if #(.ADDR_W(13), .DATA_W(8)) bus_if ();

  vec_ram_arbiter #(.ADDR_W(13), .DATA_W(8)) dut (
    .clk         (clk),
    .rst         (rst),
    .bus         (bus_if),
    .dbg_state_o (dbg_state)
  );

  always #5 clk = ~clk;

  task automatic tick(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic idle_inputs();
    bus_if.dl_wr    = 1'b0;
    bus_if.dl_addr  = '0;
    bus_if.dl_data  = '0;
    bus_if.cpu_req  = 1'b0;
    bus_if.cpu_we   = 1'b0;
    bus_if.cpu_addr = '0;
    bus_if.cpu_din  = '0;
    bus_if.avg_req  = 1'b0;
    bus_if.avg_addr = '0;
  endtask

  task automatic dl(input logic [12:0] a, input logic [7:0] d);
    bus_if.dl_wr   = 1'b1;
    bus_if.dl_addr = a;
    bus_if.dl_data = d;
    tick();
    bus_if.dl_wr   = 1'b0;
  endtask

  task automatic set_cpu(input logic we, input logic [12:0] a, input logic [7:0] d);
    bus_if.cpu_req  = 1'b1;
    bus_if.cpu_we   = we;
    bus_if.cpu_addr = a;
    bus_if.cpu_din  = d;
  endtask

  task automatic set_avg(input logic [11:0] w);
    bus_if.avg_req  = 1'b1;
    bus_if.avg_addr = w;
  endtask

  initial begin
    idle_inputs();
    // Reset with requests held high: they must be ignored.
    set_cpu(1'b0, 13'h0000, 8'h00);
    set_avg(12'h000);
    tick(2);
    rst = 1'b0;
    idle_inputs();
    chk("rst_state", 32'(dbg_state), 32'(S_IDLE));
    chk("rst_cpu_ack", 32'(bus_if.cpu_ack), 32'd0);
    chk("rst_avg_valid", 32'(bus_if.avg_valid), 32'd0);
    chk("rst_ovf", 32'(bus_if.ovf), 32'd0);
    chk("rst_cpu_dout", 32'(bus_if.cpu_dout), 32'd0);
    chk("rst_avg_inst", 32'(bus_if.avg_inst), 32'd0);
    cnt = 0;
    for (int i = 0; i < 5; i++) begin
      tick();
      cnt += int'(bus_if.cpu_ack) + int'(bus_if.avg_valid);
    end
    chk("rst_req_ignored", 32'(cnt), 32'd0);

    // Download then AVG fetch of word 0x008
    dl(13'h0010, 8'hAB);
    dl(13'h0011, 8'hCD);
    set_avg(12'h008);
    tick();
    bus_if.avg_req = 1'b0;
    chk("avg_t1_state", 32'(dbg_state), 32'(S_AVG_LO));
    tick();
    chk("avg_t2_state", 32'(dbg_state), 32'(S_AVG_FIN));
    chk("avg_t2_valid", 32'(bus_if.avg_valid), 32'd0);
    tick();
    chk("avg_t3_valid", 32'(bus_if.avg_valid), 32'd1);
    chk("avg_t3_inst", 32'(bus_if.avg_inst), 32'hABCD);
    tick();
    chk("avg_t4_valid_low", 32'(bus_if.avg_valid), 32'd0);
    chk("avg_t4_inst_held", 32'(bus_if.avg_inst), 32'hABCD);

    // CPU write 0x5A to 0x1FFF at T, read back at T+3
    set_cpu(1'b1, 13'h1FFF, 8'h5A);
    tick();
    bus_if.cpu_req = 1'b0;
    chk("cpuw_t1_ack", 32'(bus_if.cpu_ack), 32'd0);
    tick();
    chk("cpuw_t2_ack", 32'(bus_if.cpu_ack), 32'd1);
    chk("cpuw_t2_state", 32'(dbg_state), 32'(S_IDLE));
    tick();
    chk("cpuw_t3_ack_low", 32'(bus_if.cpu_ack), 32'd0);
    set_cpu(1'b0, 13'h1FFF, 8'h00);
    tick();
    bus_if.cpu_req = 1'b0;
    tick();
    chk("cpur_t5_ack", 32'(bus_if.cpu_ack), 32'd1);
    chk("cpur_t5_dout", 32'(bus_if.cpu_dout), 32'h5A);

    // Top word wraps to bytes 0x1FFE/0x1FFF
    dl(13'h1FFE, 8'h12);
    set_avg(12'hFFF);
    tick();
    bus_if.avg_req = 1'b0;
    tick(2);
    chk("wrap_valid", 32'(bus_if.avg_valid), 32'd1);
    chk("wrap_inst", 32'(bus_if.avg_inst), 32'h125A);

    // Tie from reset: CPU first, AVG three cycles after the ack
    rst = 1'b1;
    tick();
    rst = 1'b0;
    set_cpu(1'b0, 13'h0010, 8'h00);
    set_avg(12'h008);
    tick();
    idle_inputs();
    tick();
    chk("tie1_cpu_ack", 32'(bus_if.cpu_ack), 32'd1);
    chk("tie1_cpu_dout", 32'(bus_if.cpu_dout), 32'hAB);
    chk("tie1_avg_not_yet", 32'(bus_if.avg_valid), 32'd0);
    tick(3);
    chk("tie1_avg_valid", 32'(bus_if.avg_valid), 32'd1);
    chk("tie1_avg_inst", 32'(bus_if.avg_inst), 32'hABCD);
    // Second tie: AVG first
    set_cpu(1'b0, 13'h0011, 8'h00);
    set_avg(12'hFFF);
    tick();
    idle_inputs();
    tick(2);
    chk("tie2_avg_valid", 32'(bus_if.avg_valid), 32'd1);
    chk("tie2_avg_inst", 32'(bus_if.avg_inst), 32'h125A);
    chk("tie2_cpu_not_yet", 32'(bus_if.cpu_ack), 32'd0);
    tick(2);
    chk("tie2_cpu_ack", 32'(bus_if.cpu_ack), 32'd1);
    chk("tie2_cpu_dout", 32'(bus_if.cpu_dout), 32'hCD);

    // Download held for 4 cycles during AVG_LO; first write changes the low byte
    set_avg(12'h008);
    tick();
    bus_if.avg_req = 1'b0;
    for (int i = 0; i < 4; i++) begin
      bus_if.dl_wr   = 1'b1;
      bus_if.dl_addr = (i == 0) ? 13'h0011 : 13'(13'h0030 + i);
      bus_if.dl_data = (i == 0) ? 8'hEE : 8'h00;
      chk($sformatf("stall_lo_%0d", i), 32'(dbg_state), 32'(S_AVG_LO));
      chk($sformatf("stall_novalid_%0d", i), 32'(bus_if.avg_valid), 32'd0);
      tick();
    end
    bus_if.dl_wr = 1'b0;
    chk("stall_lo_release", 32'(dbg_state), 32'(S_AVG_LO));
    tick();
    chk("stall_fin", 32'(dbg_state), 32'(S_AVG_FIN));
    tick();
    chk("stall_valid", 32'(bus_if.avg_valid), 32'd1);
    chk("stall_inst", 32'(bus_if.avg_inst), 32'hABEE);

    // Second CPU request while the first is still pending behind an AVG fetch
    set_avg(12'h008);
    tick();
    bus_if.avg_req = 1'b0;
    set_cpu(1'b1, 13'h0040, 8'h77);
    tick();
    set_cpu(1'b1, 13'h0041, 8'h88);
    tick();
    bus_if.cpu_req = 1'b0;
    chk("ovf_set", 32'(bus_if.ovf), 32'd1);
    chk("ovf_avg_valid", 32'(bus_if.avg_valid), 32'd1);
    tick(2);
    chk("ovf_cpu_ack_t5", 32'(bus_if.cpu_ack), 32'd1);
    cnt = 1;
    for (int i = 0; i < 6; i++) begin
      tick();
      cnt += int'(bus_if.cpu_ack);
    end
    chk("ovf_single_ack", 32'(cnt), 32'd1);
    chk("ovf_sticky", 32'(bus_if.ovf), 32'd1);
    set_cpu(1'b0, 13'h0040, 8'h00);
    tick();
    bus_if.cpu_req = 1'b0;
    tick();
    chk("ovf_first_write", 32'(bus_if.cpu_dout), 32'h77);

    // Reset in AVG_LO abandons the fetch
    set_avg(12'hFFF);
    tick();
    bus_if.avg_req = 1'b0;
    chk("rstlo_state", 32'(dbg_state), 32'(S_AVG_LO));
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("rstlo_ovf", 32'(bus_if.ovf), 32'd0);
    chk("rstlo_idle", 32'(dbg_state), 32'(S_IDLE));
    cnt = 0;
    for (int i = 0; i < 5; i++) begin
      tick();
      cnt += int'(bus_if.avg_valid);
    end
    chk("rstlo_no_valid", 32'(cnt), 32'd0);

    // Reset during CPU_WAIT: no ack, but the issued write persists
    set_cpu(1'b1, 13'h0050, 8'h99);
    tick();
    bus_if.cpu_req = 1'b0;
    chk("rstcpu_wait", 32'(dbg_state), 32'(S_CPU_WAIT));
    rst = 1'b1;
    tick();
    rst = 1'b0;
    cnt = 0;
    for (int i = 0; i < 4; i++) begin
      cnt += int'(bus_if.cpu_ack);
      tick();
    end
    chk("rstcpu_no_ack", 32'(cnt), 32'd0);
    set_cpu(1'b0, 13'h0050, 8'h00);
    tick();
    bus_if.cpu_req = 1'b0;
    tick();
    chk("rstcpu_ack", 32'(bus_if.cpu_ack), 32'd1);
    chk("rstcpu_write_kept", 32'(bus_if.cpu_dout), 32'h99);

    // RAM contents survive the resets
    set_avg(12'h008);
    tick();
    bus_if.avg_req = 1'b0;
    tick(2);
    chk("ram_intact_valid", 32'(bus_if.avg_valid), 32'd1);
    chk("ram_intact_inst", 32'(bus_if.avg_inst), 32'hABEE);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
